draw_glyph_blitter: RTL and testbench



---
 rtl/draw_pkg.sv | 24 ++
 rtl/glyph_addr_gen.sv | 58 +++++
 rtl/draw_glyph_blitter.sv | 149 ++++++++++++++
 tb/tb_draw_glyph_blitter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared screen geometry, glyph defaults and FSM state encoding for the VGA draw blitters.
package draw_pkg;

  localparam int DRAW_SCREEN_W   = 320;
  localparam int DRAW_SCREEN_H   = 240;
  localparam int DRAW_COORD_W    = 9;
  localparam int DRAW_COLOUR_W   = 3;
  localparam int DRAW_GLYPH_W    = 20;
  localparam int DRAW_GLYPH_H    = 32;
  localparam int DRAW_NUM_GLYPHS = 10;

  typedef logic [1:0] draw_state_t;

  localparam draw_state_t ST_IDLE  = 2'd0;
  localparam draw_state_t ST_SCAN  = 2'd1;
  localparam draw_state_t ST_FLUSH = 2'd2;
  localparam draw_state_t ST_DONE  = 2'd3;

  // Width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glyph_addr_gen.sv
// Raster scanner over one glyph bitmap: x/y pixel counters and the ROM address
// glyph_base + row*GLYPH_W + column.
module glyph_addr_gen
  import draw_pkg::*;
#(
  parameter int GLYPH_W = DRAW_GLYPH_W,
  parameter int GLYPH_H = DRAW_GLYPH_H,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 13,
  parameter int XC_W    = cnt_width(GLYPH_W),
  parameter int YC_W    = cnt_width(GLYPH_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [XC_W-1:0]   o_x,
  output logic [YC_W-1:0]   o_y,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] GLYPH_SZ = ADDR_W'(GLYPH_W * GLYPH_H);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(GLYPH_W);

  logic [XC_W-1:0] r_x;
  logic [YC_W-1:0] r_y;
  logic            w_x_end;
  logic            w_y_end;

  assign w_x_end = (r_x == XC_W'(GLYPH_W - 1));
  assign w_y_end = (r_y == YC_W'(GLYPH_H - 1));

  // Both counters wrap on the final pixel so the scanner is ready for the next glyph.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + YC_W'(1);
      end else begin
        r_x <= r_x + XC_W'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;
  assign o_addr = ADDR_W'(i_idx) * GLYPH_SZ + ADDR_W'(r_y) * ROW_SZ + ADDR_W'(r_x);

endmodule

// File: rtl/draw_glyph_blitter.sv
// Glyph blitter: scans one bitmap out of the glyph ROM and plots it at a screen
// origin, clipping off-screen pixels and skipping the transparent colour.
module draw_glyph_blitter
  import draw_pkg::*;
#(
  parameter int GLYPH_W    = DRAW_GLYPH_W,
  parameter int GLYPH_H    = DRAW_GLYPH_H,
  parameter int NUM_GLYPHS = DRAW_NUM_GLYPHS,
  parameter int COORD_W    = DRAW_COORD_W,
  parameter int COLOUR_W   = DRAW_COLOUR_W,
  parameter int SCREEN_W   = DRAW_SCREEN_W,
  parameter int SCREEN_H   = DRAW_SCREEN_H,
  parameter bit KEY_EN     = 1'b1,
  parameter int KEY_COLOUR = 0,
  localparam int IDX_W     = cnt_width(NUM_GLYPHS),
  localparam int ADDR_W    = cnt_width(NUM_GLYPHS * GLYPH_W * GLYPH_H)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [IDX_W-1:0]    glyph_idx,
  input  logic [COORD_W-1:0]  initialX,
  input  logic [COORD_W-1:0]  initialY,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [COORD_W-1:0]  outputX,
  output logic [COORD_W-1:0]  outputY,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn
);

  localparam int XC_W = cnt_width(GLYPH_W);
  localparam int YC_W = cnt_width(GLYPH_H);

  draw_state_t          r_state;
  draw_state_t          w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [COORD_W-1:0]   r_x0;
  logic [COORD_W-1:0]   r_y0;
  logic                 r_pv;
  logic [XC_W-1:0]      r_px;
  logic [YC_W-1:0]      r_py;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_we;
  logic [COORD_W-1:0]   r_ox;
  logic [COORD_W-1:0]   r_oy;
  logic [COLOUR_W-1:0]  r_col;

  logic                 w_idx_ok;
  logic                 w_accept;
  logic                 w_scan;
  logic                 w_last;
  logic [XC_W-1:0]      w_x_cnt;
  logic [YC_W-1:0]      w_y_cnt;
  logic [COORD_W:0]     w_sum_x;
  logic [COORD_W:0]     w_sum_y;
  logic                 w_keyed;
  logic                 w_plot;

  assign w_idx_ok = (32'(glyph_idx) < 32'(NUM_GLYPHS));
  assign w_accept = (r_state == ST_IDLE) && start && w_idx_ok;
  assign w_scan   = (r_state == ST_SCAN);

  glyph_addr_gen #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .IDX_W   (IDX_W),
    .ADDR_W  (ADDR_W),
    .XC_W    (XC_W),
    .YC_W    (YC_W)
  ) u_addr_gen (
    .clk       (clock),
    .rst_n     (reset),
    .i_clear   (w_accept),
    .i_advance (w_scan),
    .i_idx     (r_idx),
    .o_x       (w_x_cnt),
    .o_y       (w_y_cnt),
    .o_last    (w_last),
    .o_addr    (rom_addr)
  );

  // A rejected index still spends one cycle in FLUSH so its done pulse lands two cycles after start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = w_idx_ok ? ST_SCAN : ST_FLUSH;
      ST_SCAN:  if (w_last) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Sums keep the carry bit so an overflowing coordinate clips instead of wrapping on-screen.
  assign w_sum_x = {1'b0, r_x0} + (COORD_W + 1)'(r_px);
  assign w_sum_y = {1'b0, r_y0} + (COORD_W + 1)'(r_py);
  assign w_keyed = KEY_EN && (rom_data == COLOUR_W'(KEY_COLOUR));
  assign w_plot  = r_pv && !w_keyed &&
                   (w_sum_x < (COORD_W + 1)'(SCREEN_W)) &&
                   (w_sum_y < (COORD_W + 1)'(SCREEN_H));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_pv    <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_idx <= glyph_idx;
        r_x0  <= initialX;
        r_y0  <= initialY;
      end
      r_pv   <= w_scan;
      r_px   <= w_x_cnt;
      r_py   <= w_y_cnt;
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (r_state == ST_DONE);
      r_we   <= w_plot;
      if (w_plot) begin
        r_ox  <= w_sum_x[COORD_W-1:0];
        r_oy  <= w_sum_y[COORD_W-1:0];
        r_col <= rom_data;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign writeEn = r_we;
  assign outputX = r_ox;
  assign outputY = r_oy;
  assign colour  = r_col;

endmodule

// File: tb/tb_draw_glyph_blitter.sv
// Bench for draw_glyph_blitter: keyed and unkeyed instances share stimulus; plots are
// compared against a pixel-by-pixel reference raster computed from the ROM image.
module tb_draw_glyph_blitter;

  localparam int GW = 20;
  localparam int GH = 32;
  localparam int GSZ = GW * GH;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  glyph_idx = '0;
  logic [8:0]  initialX = '0;
  logic [8:0]  initialY = '0;

  logic        busy_k, done_k, we_k, busy_n, done_n, we_n;
  logic [12:0] rom_addr_k, rom_addr_n;
  logic [2:0]  rom_data_k, rom_data_n, col_k, col_n;
  logic [8:0]  ox_k, oy_k, ox_n, oy_n;

  logic [2:0]  rom_mem [0:10*GSZ-1];

  typedef struct { int x; int y; int c; int t; } plot_t;
  typedef struct { int idx; int x0; int y0; int wk; int wn; } vec_t;

  plot_t qk[$], qn[$], exp_k[$], exp_n[$];
  int    dk[$], dn[$];
  int    cyc = 0;
  int    t0 = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    hold_mon = 1'b0;
  int    busy_gap = 0;
  vec_t  tbl[8];

  always #5 clock = ~clock;

  draw_glyph_blitter #(.KEY_EN(1'b1)) dut_k (
    .clock(clock), .reset(reset), .start(start), .glyph_idx(glyph_idx),
    .initialX(initialX), .initialY(initialY), .busy(busy_k), .done(done_k),
    .rom_addr(rom_addr_k), .rom_data(rom_data_k), .outputX(ox_k), .outputY(oy_k),
    .colour(col_k), .writeEn(we_k));

  draw_glyph_blitter #(.KEY_EN(1'b0)) dut_n (
    .clock(clock), .reset(reset), .start(start), .glyph_idx(glyph_idx),
    .initialX(initialX), .initialY(initialY), .busy(busy_n), .done(done_n),
    .rom_addr(rom_addr_n), .rom_data(rom_data_n), .outputX(ox_n), .outputY(oy_n),
    .colour(col_n), .writeEn(we_n));

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    rom_data_k <= rom_mem[rom_addr_k];
    rom_data_n <= rom_mem[rom_addr_n];
  end

  always @(negedge clock) begin
    if (we_k) qk.push_back('{int'(ox_k), int'(oy_k), int'(col_k), cyc});
    if (we_n) qn.push_back('{int'(ox_n), int'(oy_n), int'(col_n), cyc});
    if (done_k) begin
      dk.push_back(cyc);
      n_cmp++;
      if (busy_k) begin n_bad++; $display("FAIL busy_with_done key: busy=1 done=1 at cycle %0d, required busy=0", cyc); end
    end
    if (done_n) begin
      dn.push_back(cyc);
      n_cmp++;
      if (busy_n) begin n_bad++; $display("FAIL busy_with_done nokey: busy=1 done=1 at cycle %0d, required busy=0", cyc); end
    end
    if (hold_mon && !busy_k && cyc >= t0 && cyc < t0 + 1285) busy_gap++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference raster: every glyph pixel in scan order, clipped to the screen, optionally keyed.
  task automatic model(input int idx, input int x0, input int y0);
    int c, px, py;
    exp_k.delete();
    exp_n.delete();
    if (idx >= 10) return;
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        c  = int'(rom_mem[idx * GSZ + y * GW + x]);
        px = x0 + x;
        py = y0 + y;
        if (px < 320 && py < 240) begin
          exp_n.push_back('{px, py, c, 2 + y * GW + x});
          if (c != 0) exp_k.push_back('{px, py, c, 2 + y * GW + x});
        end
      end
    end
  endtask

  task automatic seq_cmp(input string tag, input bit which);
    plot_t g[$], e[$];
    int bad = -1;
    g = which ? qn : qk;
    e = which ? exp_n : exp_k;
    for (int i = 0; i < e.size() && i < g.size(); i++)
      if (bad < 0 && (g[i].x != e[i].x || g[i].y != e[i].y || g[i].c != e[i].c || g[i].t - t0 != e[i].t))
        bad = i;
    if (bad < 0 && g.size() != e.size()) bad = (g.size() < e.size()) ? g.size() : e.size();
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      if (bad < g.size() && bad < e.size())
        $display("FAIL %s plots %s: plot %0d got (%0d,%0d) c=%0d t=%0d, required (%0d,%0d) c=%0d t=%0d",
                 tag, which ? "nokey" : "key", bad, g[bad].x, g[bad].y, g[bad].c, g[bad].t - t0,
                 e[bad].x, e[bad].y, e[bad].c, e[bad].t);
      else
        $display("FAIL %s plots %s: got %0d plots, required %0d", tag, which ? "nokey" : "key", g.size(), e.size());
    end
  endtask

  task automatic clear_mon();
    qk.delete(); qn.delete(); dk.delete(); dn.delete();
  endtask

  task automatic launch(input int idx, input int x0, input int y0);
    @(negedge clock);
    clear_mon();
    start = 1'b1; glyph_idx = 4'(idx); initialX = 9'(x0); initialY = 9'(y0);
    t0 = cyc + 1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (dk.size() == 0 && n < budget) begin @(negedge clock); n++; end
    if (dk.size() == 0) check({tag, " done_timeout"}, 0, 1);
    repeat (8) @(negedge clock);
  endtask

  task automatic verify(input string tag, input int idx, input int wk, input int wn);
    int exp_done = (idx < 10) ? 642 : 2;
    check({tag, " writes key"}, qk.size(), wk);
    check({tag, " writes nokey"}, qn.size(), wn);
    seq_cmp(tag, 1'b0);
    seq_cmp(tag, 1'b1);
    check({tag, " done count key"}, dk.size(), 1);
    check({tag, " done count nokey"}, dn.size(), 1);
    if (dk.size() > 0) check({tag, " done latency key"}, dk[0] - t0, exp_done);
    if (dn.size() > 0) check({tag, " done latency nokey"}, dn[0] - t0, exp_done);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, int'(busy_k) + int'(busy_n), 0);
    check({tag, " done"}, int'(done_k) + int'(done_n), 0);
    check({tag, " writeEn"}, int'(we_k) + int'(we_n), 0);
    check({tag, " outputX"}, int'(ox_k) + int'(ox_n), 0);
    check({tag, " outputY"}, int'(oy_k) + int'(oy_n), 0);
    check({tag, " colour"}, int'(col_k) + int'(col_n), 0);
    check({tag, " rom_addr"}, int'(rom_addr_k) + int'(rom_addr_n), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros, idx, x0, y0;

    // ROM: nonzero everywhere, glyph 3 solid colour 5, glyph 7 with even pixels transparent.
    for (int a = 0; a < 10 * GSZ; a++) rom_mem[a] = 3'($urandom_range(1, 7));
    for (int a = 0; a < GSZ; a++) rom_mem[3 * GSZ + a] = 3'd5;
    for (int a = 0; a < GSZ; a += 2) rom_mem[7 * GSZ + a] = 3'd0;

    repeat (3) @(negedge clock);
    check_zero("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    tbl[0] = '{3, 100, 50, 640, 640};
    tbl[1] = '{0, 310, 220, 200, 200};
    tbl[2] = '{7, 10, 10, 320, 640};
    tbl[3] = '{12, 0, 0, 0, 0};
    tbl[4] = '{2, 300, 230, 200, 200};
    tbl[5] = '{5, 511, 511, 0, 0};
    tbl[6] = '{4, 319, 239, 1, 1};
    tbl[7] = '{9, 0, 0, 640, 640};

    for (int i = 0; i < 8; i++) begin
      model(tbl[i].idx, tbl[i].x0, tbl[i].y0);
      launch(tbl[i].idx, tbl[i].x0, tbl[i].y0);
      wait_done($sformatf("vec%0d", i), 2000);
      verify($sformatf("vec%0d", i), tbl[i].idx, tbl[i].wk, tbl[i].wn);
      $display("vec%0d idx=%0d at (%0d,%0d): key writes %0d, nokey writes %0d",
               i, tbl[i].idx, tbl[i].x0, tbl[i].y0, qk.size(), qn.size());
      if (tbl[i].idx == 3 && qk.size() == 640) begin
        check("glyph3 first x", qk[0].x, 100);
        check("glyph3 first y", qk[0].y, 50);
        check("glyph3 first latency", qk[0].t - t0, 2);
        check("glyph3 last x", qk[639].x, 119);
        check("glyph3 last y", qk[639].y, 81);
        check("glyph3 last colour", qk[639].c, 5);
      end
      if (tbl[i].idx == 7) begin
        zeros = 0;
        foreach (qk[j]) if (qk[j].c == 0) zeros++;
        check("glyph7 keyed zero-colour writes", zeros, 0);
      end
    end

    // Rejected index, with a second start one cycle later that must be ignored.
    @(negedge clock);
    clear_mon();
    start = 1'b1; glyph_idx = 4'd12; initialX = '0; initialY = '0;
    t0 = cyc + 1;
    @(negedge clock);
    glyph_idx = 4'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    check("badidx done count", dk.size(), 1);
    if (dk.size() > 0) check("badidx done latency", dk[0] - t0, 2);
    check("badidx writes", qk.size() + qn.size(), 0);
    check("badidx busy after", int'(busy_k), 0);
    $display("badidx: done pulses %0d, writes %0d", dk.size(), qk.size());

    // Reset in the middle of a glyph.
    launch(1, 50, 60);
    for (int n = 0; n < 400 && qk.size() < 100; n++) @(negedge clock);
    check("midreset reached pixel 100", int'(qk.size() >= 100), 1);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    clear_mon();
    repeat (50) @(negedge clock);
    check("post-reset idle writes", qk.size() + qn.size(), 0);
    check("post-reset idle done", dk.size() + dn.size(), 0);
    model(1, 50, 60);
    launch(1, 50, 60);
    wait_done("restart", 2000);
    verify("restart", 1, 640, 640);
    $display("midreset: restart drew %0d plots", qk.size());

    // start held high for 700 cycles gives two back-to-back runs.
    @(negedge clock);
    clear_mon();
    busy_gap = 0;
    start = 1'b1; glyph_idx = 4'd6; initialX = 9'd20; initialY = 9'd30;
    t0 = cyc + 1;
    hold_mon = 1'b1;
    repeat (700) @(negedge clock);
    start = 1'b0;
    while (cyc < t0 + 1300) @(negedge clock);
    hold_mon = 1'b0;
    check("held done count", dk.size(), 2);
    if (dk.size() > 0) check("held done1 latency", dk[0] - t0, 642);
    if (dk.size() > 1) check("held done2 latency", dk[1] - t0, 1285);
    check("held writes", qk.size(), 1280);
    check("held busy-low cycles between runs", busy_gap, 1);
    $display("held start: done pulses %0d, writes %0d, idle gap %0d", dk.size(), qk.size(), busy_gap);

    // Randomized runs with transparent pixels scattered through the ROM.
    for (int a = 0; a < 10 * GSZ; a++) rom_mem[a] = 3'($urandom_range(0, 7));
    for (int r = 0; r < 8; r++) begin
      idx = $urandom_range(0, 11);
      x0  = $urandom_range(0, 340);
      y0  = (r == 7) ? 500 : $urandom_range(0, 250);
      model(idx, x0, y0);
      launch(idx, x0, y0);
      wait_done($sformatf("rand%0d", r), 2000);
      verify($sformatf("rand%0d", r), idx, exp_k.size(), exp_n.size());
      $display("rand%0d idx=%0d at (%0d,%0d): key writes %0d, nokey writes %0d",
               r, idx, x0, y0, qk.size(), qn.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
